// File: rtl/obj_alloc_pkg.sv
// Shared types for the object allocator: FSM state encoding and request
// arbitration between the matrix unit's simultaneous commands.
package obj_alloc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Enum order mirrors arbitration rank, highest last.
  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_REF     = 3'd1,
    REQ_CRT     = 3'd2,
    REQ_DEL     = 3'd3,
    REQ_DEL_ALL = 3'd4
  } req_e;

  function automatic req_e pick_req(input logic del_all, input logic del_obj,
                                    input logic crt_obj, input logic ref_addr);
    if (del_all)       return REQ_DEL_ALL;
    else if (del_obj)  return REQ_DEL;
    else if (crt_obj)  return REQ_CRT;
    else if (ref_addr) return REQ_REF;
    else               return REQ_NONE;
  endfunction

endpackage

// File: rtl/obj_alloc_unit_if.sv
// Command/response bus between the matrix unit and the object allocator.
interface obj_alloc_unit_if #(
  parameter int NUM_OBJ = 32
);
  localparam int ADDR_W = $clog2(NUM_OBJ);

  logic              crt_obj;
  logic              del_obj;
  logic              del_all;
  logic              ref_addr;
  logic              changed_in;
  logic [ADDR_W-1:0] obj_num;
  logic [ADDR_W-1:0] addr;
  logic              addr_vld;
  logic              err;

  modport master (
    output crt_obj, del_obj, del_all, ref_addr, changed_in, obj_num,
    input  addr, addr_vld, err
  );

  modport slave (
    input  crt_obj, del_obj, del_all, ref_addr, changed_in, obj_num,
    output addr, addr_vld, err
  );

endinterface

// File: rtl/obj_alloc_unit_lowest_free_enc.sv
// Priority encoder returning the lowest set bit of a free-slot vector.
module lowest_free_enc #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] free,
  output logic [IDX_W-1:0] idx,
  output logic             none_free
);

  always_comb begin
    idx = '0;
    // Scanning downward lets the lowest free index overwrite higher ones.
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (free[i-1]) idx = IDX_W'(i - 1);
    end
    none_free = ~|free;
  end

endmodule

// File: rtl/obj_alloc_unit.sv
// Object slot allocator: lowest-free create, delete, reference validation,
// per-slot changed tracking for the clipper and a delete-all memory sweep.
module obj_alloc_unit
  import obj_alloc_pkg::*;
#(
  parameter  int NUM_OBJ = 32,
  localparam int ADDR_W  = $clog2(NUM_OBJ)
) (
  input  logic               clk,
  input  logic               rst_n,
  obj_alloc_unit_if.slave    bus,
  output logic [ADDR_W-1:0]  lst_stored_obj,
  output logic               lst_stored_obj_vld,
  output logic               obj_mem_full,
  output logic [ADDR_W:0]    obj_cnt,
  output logic               busy,
  output logic [ADDR_W-1:0]  clr_addr,
  output logic               clr_we,
  output logic [NUM_OBJ-1:0] obj_map,
  output logic [NUM_OBJ-1:0] chg_map,
  input  logic               clip_ack,
  input  logic [ADDR_W-1:0]  clip_addr
);

  localparam int CNT_W = ADDR_W + 1;

  state_e             state;
  req_e               req;
  logic [ADDR_W-1:0]  addr_q;
  logic               addr_vld_q;
  logic               err_q;
  logic [ADDR_W-1:0]  free_idx;
  logic               none_free;
  logic               tgt_valid;
  logic [NUM_OBJ-1:0] map_set, map_clr, chg_set, chg_clr;
  logic [NUM_OBJ-1:0] map_next, chg_next;
  logic               cnt_inc, cnt_dec;
  logic [CNT_W-1:0]   cnt_next;

  assign bus.addr     = addr_q;
  assign bus.addr_vld = addr_vld_q;
  assign bus.err      = err_q;

  lowest_free_enc #(.WIDTH(NUM_OBJ)) u_enc (
    .free      (~obj_map),
    .idx       (free_idx),
    .none_free (none_free)
  );

  assign req       = pick_req(bus.del_all, bus.del_obj, bus.crt_obj, bus.ref_addr);
  assign tgt_valid = obj_map[bus.obj_num];

  always_comb begin
    map_set = '0;
    map_clr = '0;
    chg_set = '0;
    chg_clr = '0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (clip_ack) chg_clr[clip_addr] = 1'b1;
    if (state == ST_SWEEP) begin
      map_clr[clr_addr] = 1'b1;
      chg_set[clr_addr] = 1'b1;
      cnt_dec           = obj_map[clr_addr];
    end else begin
      case (req)
        REQ_CRT: if (!none_free) begin
          map_set[free_idx] = 1'b1;
          chg_set[free_idx] = 1'b1;
          cnt_inc           = 1'b1;
        end
        REQ_DEL: if (tgt_valid) begin
          map_clr[bus.obj_num] = 1'b1;
          chg_set[bus.obj_num] = 1'b1;
          cnt_dec              = 1'b1;
        end
        REQ_REF: if (tgt_valid && bus.changed_in) chg_set[bus.obj_num] = 1'b1;
        default: ;
      endcase
    end
    // Applying the set after the clear makes a coincident set win.
    map_next = (obj_map & ~map_clr) | map_set;
    chg_next = (chg_map & ~chg_clr) | chg_set;
    cnt_next = obj_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      addr_q             <= '0;
      addr_vld_q         <= 1'b0;
      err_q              <= 1'b0;
      lst_stored_obj     <= '0;
      lst_stored_obj_vld <= 1'b0;
      obj_mem_full       <= 1'b0;
      obj_cnt            <= '0;
      busy               <= 1'b0;
      clr_addr           <= '0;
      clr_we             <= 1'b0;
      obj_map            <= '0;
      chg_map            <= '0;
    end else begin
      addr_vld_q   <= 1'b0;
      err_q        <= 1'b0;
      obj_map      <= map_next;
      chg_map      <= chg_next;
      obj_cnt      <= cnt_next;
      obj_mem_full <= (cnt_next == CNT_W'(NUM_OBJ));
      case (state)
        ST_IDLE: begin
          case (req)
            REQ_DEL_ALL: begin
              state    <= ST_SWEEP;
              busy     <= 1'b1;
              clr_we   <= 1'b1;
              clr_addr <= '0;
            end
            REQ_DEL, REQ_REF: begin
              if (tgt_valid) begin
                addr_q     <= bus.obj_num;
                addr_vld_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            REQ_CRT: begin
              if (none_free) begin
                err_q <= 1'b1;
              end else begin
                addr_q             <= free_idx;
                addr_vld_q         <= 1'b1;
                lst_stored_obj     <= free_idx;
                lst_stored_obj_vld <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_SWEEP: begin
          if (req != REQ_NONE) err_q <= 1'b1;
          if (clr_addr == ADDR_W'(NUM_OBJ - 1)) begin
            state              <= ST_IDLE;
            busy               <= 1'b0;
            clr_we             <= 1'b0;
            clr_addr           <= '0;
            obj_cnt            <= '0;
            obj_mem_full       <= 1'b0;
            lst_stored_obj_vld <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_alloc_unit.sv
// Directed bench for obj_alloc_unit with 32 slots; expected values hand-computed.
module tb_obj_alloc_unit;

  localparam int NUM_OBJ = 32;
  localparam int ADDR_W  = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [ADDR_W-1:0]  lst_stored_obj;
  logic               lst_stored_obj_vld;
  logic               obj_mem_full;
  logic [ADDR_W:0]    obj_cnt;
  logic               busy;
  logic [ADDR_W-1:0]  clr_addr;
  logic               clr_we;
  logic [NUM_OBJ-1:0] obj_map;
  logic [NUM_OBJ-1:0] chg_map;
  logic               clip_ack = 1'b0;
  logic [ADDR_W-1:0]  clip_addr = '0;

  int checks = 0;
  int errors = 0;
  int n;

  obj_alloc_unit_if #(.NUM_OBJ(NUM_OBJ)) bus ();

  obj_alloc_unit #(.NUM_OBJ(NUM_OBJ)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus.slave),
    .lst_stored_obj     (lst_stored_obj),
    .lst_stored_obj_vld (lst_stored_obj_vld),
    .obj_mem_full       (obj_mem_full),
    .obj_cnt            (obj_cnt),
    .busy               (busy),
    .clr_addr           (clr_addr),
    .clr_we             (clr_we),
    .obj_map            (obj_map),
    .chg_map            (chg_map),
    .clip_ack           (clip_ack),
    .clip_addr          (clip_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic c, input logic d, input logic da, input logic r,
                     input logic ch, input logic [ADDR_W-1:0] num);
    bus.crt_obj = c; bus.del_obj = d; bus.del_all = da; bus.ref_addr = r;
    bus.changed_in = ch; bus.obj_num = num;
    cycle();
    bus.crt_obj = 0; bus.del_obj = 0; bus.del_all = 0; bus.ref_addr = 0;
    bus.changed_in = 0; bus.obj_num = '0;
  endtask

  initial begin
    bus.crt_obj = 0; bus.del_obj = 0; bus.del_all = 0; bus.ref_addr = 0;
    bus.changed_in = 0; bus.obj_num = '0;

    // Reset state
    repeat (2) cycle();
    chk("rst_vld", bus.addr_vld, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_cnt", obj_cnt, 0);
    chk("rst_map", obj_map, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycle();

    // Three creates
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 0, 0, 0, 0);
      chk("crt_addr", bus.addr, i);
      chk("crt_vld", bus.addr_vld, 1);
    end
    chk("crt3_cnt", obj_cnt, 3);
    chk("crt3_lst", lst_stored_obj, 2);
    chk("crt3_lstvld", lst_stored_obj_vld, 1);
    chk("crt3_chg", chg_map, 32'h7);
    cycle();
    chk("vld_pulse", bus.addr_vld, 0);

    // Fill, then overflow
    for (int i = 3; i < 32; i++) req(1, 0, 0, 0, 0, 0);
    chk("fill_full", obj_mem_full, 1);
    chk("fill_cnt", obj_cnt, 32);
    chk("fill_map", obj_map, 32'hFFFF_FFFF);
    req(1, 0, 0, 0, 0, 0);
    chk("ovf_err", bus.err, 1);
    chk("ovf_vld", bus.addr_vld, 0);
    chk("ovf_cnt", obj_cnt, 32);

    // Delete 5 then recreate into the hole
    req(0, 1, 0, 0, 0, 5);
    chk("del5_addr", bus.addr, 5);
    chk("del5_vld", bus.addr_vld, 1);
    chk("del5_full", obj_mem_full, 0);
    chk("del5_cnt", obj_cnt, 31);
    chk("del5_map", obj_map, 32'hFFFF_FFDF);
    req(1, 0, 0, 0, 0, 0);
    chk("re5_addr", bus.addr, 5);
    chk("re5_full", obj_mem_full, 1);

    // Invalid reference, then create beats a simultaneous ref
    req(0, 1, 0, 0, 0, 9);
    req(0, 0, 0, 1, 0, 9);
    chk("ref9_err", bus.err, 1);
    chk("ref9_vld", bus.addr_vld, 0);
    req(1, 0, 0, 1, 0, 9);
    chk("prio_addr", bus.addr, 9);
    chk("prio_err", bus.err, 0);
    chk("prio_cnt", obj_cnt, 32);

    // Clip ack then references on slot 2
    clip_ack = 1; clip_addr = 2;
    cycle();
    clip_ack = 0;
    chk("clip2_chg", chg_map, 32'hFFFF_FFFB);
    req(0, 0, 0, 1, 0, 2);
    chk("ref2_vld", bus.addr_vld, 1);
    chk("ref2_nochg", chg_map, 32'hFFFF_FFFB);
    req(0, 0, 0, 1, 1, 2);
    chk("ref2_addr", bus.addr, 2);
    chk("ref2_chg", chg_map, 32'hFFFF_FFFF);

    // Set wins over clear on the same bit
    clip_ack = 1; clip_addr = 4;
    cycle();
    chk("clip4_chg", chg_map, 32'hFFFF_FFEF);
    req(0, 1, 0, 0, 0, 4);
    clip_ack = 0;
    chk("setwin_chg", chg_map, 32'hFFFF_FFFF);
    chk("setwin_map", obj_map, 32'hFFFF_FFEF);
    chk("setwin_cnt", obj_cnt, 31);

    // Sweep from 31 objects, length only
    req(0, 0, 1, 0, 0, 0);
    n = 0;
    while (busy && n < 40) begin cycle(); n++; end
    chk("sweepA_len", n, 32);
    chk("sweepA_cnt", obj_cnt, 0);
    chk("sweepA_lstvld", lst_stored_obj_vld, 0);

    // Ten objects, one changed bit cleared, then a fully checked sweep
    for (int i = 0; i < 10; i++) begin
      req(1, 0, 0, 0, 0, 0);
      chk("c10_addr", bus.addr, i);
    end
    chk("c10_map", obj_map, 32'h3FF);
    chk("c10_cnt", obj_cnt, 10);
    clip_ack = 1; clip_addr = 20;
    cycle();
    clip_ack = 0;
    chk("clip20_chg", chg_map, 32'hFFEF_FFFF);
    req(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      chk("swp_busy", busy, 1);
      chk("swp_we", clr_we, 1);
      chk("swp_addr", clr_addr, k);
      if (k == 11) chk("swp_err", bus.err, 1);
      if (k == 10) bus.crt_obj = 1;
      cycle();
      bus.crt_obj = 0;
    end
    chk("swpB_busy", busy, 0);
    chk("swpB_we", clr_we, 0);
    chk("swpB_addr", clr_addr, 0);
    chk("swpB_map", obj_map, 0);
    chk("swpB_cnt", obj_cnt, 0);
    chk("swpB_chg", chg_map, 32'hFFFF_FFFF);
    chk("swpB_lstvld", lst_stored_obj_vld, 0);

    // Reset in the middle of another sweep
    for (int i = 0; i < 3; i++) req(1, 0, 0, 0, 0, 0);
    req(0, 0, 1, 0, 0, 0);
    repeat (15) cycle();
    chk("swpC_addr", clr_addr, 15);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", clr_we, 0);
    chk("arst_addr", clr_addr, 0);
    chk("arst_map", obj_map, 0);
    chk("arst_chg", chg_map, 0);
    chk("arst_cnt", obj_cnt, 0);
    chk("arst_lst", lst_stored_obj, 0);
    chk("arst_baddr", bus.addr, 0);
    rst_n = 1'b1;
    cycle();
    chk("post_busy", busy, 0);
    req(1, 0, 0, 0, 0, 0);
    chk("post_addr", bus.addr, 0);
    chk("post_vld", bus.addr_vld, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
